// File: rtl/tim_arb_pkg.sv
// -----------------------------------------------------------------------------
// tim_arb_pkg
// Shared types and constants for the timer-bank APB arbiter.
//   - arb_state_e : FSM state encoding (IDLE / SETUP / ACCESS)
//   - tim_req_t   : one latched requester transfer (write flag, address, data)
//   - TIM_ADDR_W / TIM_DATA_W : APB address and data widths
//   - TIM_TIMEOUT_DEFAULT     : default ACCESS-phase wait limit
//   - TIM_WAIT_W              : width of the optional wait counter
// -----------------------------------------------------------------------------
package tim_arb_pkg;

  localparam int TIM_ADDR_W          = 32;
  localparam int TIM_DATA_W          = 32;
  localparam int TIM_TIMEOUT_DEFAULT = 16;
  localparam int TIM_WAIT_W          = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [TIM_ADDR_W-1:0] addr;
    logic [TIM_DATA_W-1:0] wdata;
  } tim_req_t;

  // Select the transfer of the granted requester (sel = 1 picks port 1).
  function automatic tim_req_t pick_req(input logic sel,
                                        input tim_req_t r0,
                                        input tim_req_t r1);
    tim_req_t res;
    if (sel) begin
      res = r1;
    end else begin
      res = r0;
    end
    return res;
  endfunction

endpackage

// File: rtl/tim_arb_rr.sv
// -----------------------------------------------------------------------------
// tim_arb_rr
// Combinational two-way round-robin picker.
// Ports:
//   valid[1:0]   in  : requesters with a pending transfer
//   last_grant   in  : index of the requester granted most recently
//   exclude[1:0] in  : requesters that may not be granted this cycle
//                      (their completion pulse is still visible to them)
//   grant[1:0]   out : one-hot winner, or zero when nobody is eligible
// -----------------------------------------------------------------------------
module tim_arb_rr
  import tim_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic [1:0] exclude,
  output logic [1:0] grant
);

  logic [1:0] elig_s;

  // Pick the single eligible requester, or on a tie the one not served last.
  always_comb begin
    elig_s = valid & ~exclude;
    grant  = 2'b00;
    case (elig_s)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (last_grant) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/tim_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tim_apb_arbiter
// Shares the timer APB slave port between two requesters (CPU bridge and
// configuration sequencer) with round-robin arbitration.
//
// Optional feature: define TIM_ARB_TIMEOUT_EN to enable an ACCESS-phase
// watchdog that aborts a transfer after TIMEOUT_CYCLES cycles without
// tim_pready and reports it through req*_err. Without the macro ACCESS waits
// indefinitely and req*_err are constant 0.
//
// Parameters:
//   TIMEOUT_CYCLES : ACCESS cycles to wait for tim_pready (watchdog only)
// Ports:
//   sys_clk, sys_rst          : clock, asynchronous active-high reset
//   reqN_valid/write/addr/wdata : requester N transfer request (held to done)
//   reqN_done                 : one-cycle completion pulse
//   reqN_rdata                : read data, held until next completion on N
//   reqN_err                  : watchdog expiry, valid with reqN_done
//   tim_psel/penable/pwrite/paddr/pwdata : APB master outputs
//   tim_prdata/pready         : APB slave responses
// -----------------------------------------------------------------------------
module tim_apb_arbiter
  import tim_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIM_TIMEOUT_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [TIM_ADDR_W-1:0] req0_addr,
  input  logic [TIM_DATA_W-1:0] req0_wdata,
  output logic                  req0_done,
  output logic [TIM_DATA_W-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [TIM_ADDR_W-1:0] req1_addr,
  input  logic [TIM_DATA_W-1:0] req1_wdata,
  output logic                  req1_done,
  output logic [TIM_DATA_W-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  tim_psel,
  output logic                  tim_penable,
  output logic                  tim_pwrite,
  output logic [TIM_ADDR_W-1:0] tim_paddr,
  output logic [TIM_DATA_W-1:0] tim_pwdata,
  input  logic [TIM_DATA_W-1:0] tim_prdata,
  input  logic                  tim_pready
);

  arb_state_e            state_r;
  logic                  owner_r;
  logic                  last_grant_r;
  logic [1:0]            grant_s;
  tim_req_t              req0_s;
  tim_req_t              req1_s;
  tim_req_t              win_s;

  logic                  psel_r;
  logic                  penable_r;
  logic                  pwrite_r;
  logic [TIM_ADDR_W-1:0] paddr_r;
  logic [TIM_DATA_W-1:0] pwdata_r;

  logic                  done0_r;
  logic                  done1_r;
  logic [TIM_DATA_W-1:0] rdata0_r;
  logic [TIM_DATA_W-1:0] rdata1_r;

  assign req0_s = {req0_write, req0_addr, req0_wdata};
  assign req1_s = {req1_write, req1_addr, req1_wdata};
  assign win_s  = pick_req(grant_s[1], req0_s, req1_s);

  // A port whose done is visible this cycle still shows valid for the
  // transfer that just finished, so it must not be granted again.
  tim_arb_rr u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_r),
    .exclude    ({done1_r, done0_r}),
    .grant      (grant_s)
  );

`ifdef TIM_ARB_TIMEOUT_EN
  // The counter holds the number of ACCESS cycles already spent without
  // pready; expiry fires when this cycle would bring it to TIMEOUT_CYCLES.
  localparam logic [TIM_WAIT_W-1:0] WAIT_LIMIT = TIM_WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [TIM_WAIT_W-1:0] wait_cnt_r;
  logic                  expire_s;
  logic                  err0_r;
  logic                  err1_r;

  assign expire_s = (wait_cnt_r == WAIT_LIMIT);

  // ACCESS wait counter: cleared in SETUP, counts ACCESS cycles without pready.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wait_cnt_r <= {TIM_WAIT_W{1'b0}};
    end else if (state_r == ST_SETUP) begin
      wait_cnt_r <= {TIM_WAIT_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && !tim_pready) begin
      wait_cnt_r <= wait_cnt_r + {{(TIM_WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign req0_err = err0_r;
  assign req1_err = err1_r;
`else
  assign req0_err = 1'b0;
  assign req1_err = 1'b0;
`endif

  // Arbiter FSM with request latch, registered APB outputs and per-port
  // completion registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      psel_r       <= 1'b0;
      penable_r    <= 1'b0;
      pwrite_r     <= 1'b0;
      paddr_r      <= {TIM_ADDR_W{1'b0}};
      pwdata_r     <= {TIM_DATA_W{1'b0}};
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
      rdata0_r     <= {TIM_DATA_W{1'b0}};
      rdata1_r     <= {TIM_DATA_W{1'b0}};
`ifdef TIM_ARB_TIMEOUT_EN
      err0_r       <= 1'b0;
      err1_r       <= 1'b0;
`endif
    end else begin
      done0_r <= 1'b0;
      done1_r <= 1'b0;
`ifdef TIM_ARB_TIMEOUT_EN
      err0_r  <= 1'b0;
      err1_r  <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (grant_s != 2'b00) begin
            state_r      <= ST_SETUP;
            owner_r      <= grant_s[1];
            last_grant_r <= grant_s[1];
            psel_r       <= 1'b1;
            penable_r    <= 1'b0;
            pwrite_r     <= win_s.write;
            paddr_r      <= win_s.addr;
            pwdata_r     <= win_s.wdata;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SETUP: begin
          state_r   <= ST_ACCESS;
          penable_r <= 1'b1;
        end

        ST_ACCESS: begin
          // pready wins over a simultaneous watchdog expiry.
          if (tim_pready) begin
            state_r   <= ST_IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {TIM_ADDR_W{1'b0}};
            pwdata_r  <= {TIM_DATA_W{1'b0}};
            if (owner_r) begin
              done1_r <= 1'b1;
              if (!pwrite_r) begin
                rdata1_r <= tim_prdata;
              end
            end else begin
              done0_r <= 1'b1;
              if (!pwrite_r) begin
                rdata0_r <= tim_prdata;
              end
            end
          end
`ifdef TIM_ARB_TIMEOUT_EN
          else if (expire_s) begin
            state_r   <= ST_IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {TIM_ADDR_W{1'b0}};
            pwdata_r  <= {TIM_DATA_W{1'b0}};
            if (owner_r) begin
              done1_r  <= 1'b1;
              err1_r   <= 1'b1;
              rdata1_r <= {TIM_DATA_W{1'b0}};
            end else begin
              done0_r  <= 1'b1;
              err0_r   <= 1'b1;
              rdata0_r <= {TIM_DATA_W{1'b0}};
            end
          end
`endif
          else begin
            state_r <= ST_ACCESS;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          psel_r    <= 1'b0;
          penable_r <= 1'b0;
          pwrite_r  <= 1'b0;
          paddr_r   <= {TIM_ADDR_W{1'b0}};
          pwdata_r  <= {TIM_DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign tim_psel    = psel_r;
  assign tim_penable = penable_r;
  assign tim_pwrite  = pwrite_r;
  assign tim_paddr   = paddr_r;
  assign tim_pwdata  = pwdata_r;
  assign req0_done   = done0_r;
  assign req1_done   = done1_r;
  assign req0_rdata  = rdata0_r;
  assign req1_rdata  = rdata1_r;

endmodule

// File: tb/tb_tim_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tim_apb_arbiter
// Cycle-level bench: two requester agents fed from item queues, an APB slave
// with chosen or random wait states, and a transaction-phase reference model
// (idle / setup / access plus round-robin rule) checked every clock.
// -----------------------------------------------------------------------------
module tb_tim_apb_arbiter;

  localparam int TIMEOUT = 16;
`ifdef TIM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        req0_valid, req0_write, req0_done, req0_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_done, req1_err;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        tim_psel, tim_penable, tim_pwrite, tim_pready;
  logic [31:0] tim_paddr, tim_pwdata, tim_prdata;

  tim_apb_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req0_valid  (req0_valid),
    .req0_write  (req0_write),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_done   (req0_done),
    .req0_rdata  (req0_rdata),
    .req0_err    (req0_err),
    .req1_valid  (req1_valid),
    .req1_write  (req1_write),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_done   (req1_done),
    .req1_rdata  (req1_rdata),
    .req1_err    (req1_err),
    .tim_psel    (tim_psel),
    .tim_penable (tim_penable),
    .tim_pwrite  (tim_pwrite),
    .tim_paddr   (tim_paddr),
    .tim_pwdata  (tim_pwdata),
    .tim_prdata  (tim_prdata),
    .tim_pready  (tim_pready)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } item_t;

  item_t       rq0[$];
  item_t       rq1[$];
  item_t       cur[2];
  logic        vld[2];
  int          gapc[2];
  int          waits[$];
  logic [31:0] rdq[$];
  logic        order_log[$];

  // reference model state
  int          m_phase;   // 0 idle, 1 setup, 2 access
  int          m_owner;
  int          m_last;
  logic [1:0]  m_done;
  logic [1:0]  m_err;
  logic [31:0] rd_exp[2];
  item_t       bus;
  int          acc_n;
  int          w_cur;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // One clock: advance the model over the edge just taken, compare, then drive.
  task automatic tick();
    logic [1:0] elig;
    logic [1:0] done_n;
    logic [1:0] err_n;
    int         win;
    @(negedge sys_clk);
    done_n = 2'b00;
    err_n  = 2'b00;
    if (sys_rst) begin
      m_phase   = 0;
      m_last    = 1;
      rd_exp[0] = 32'h0;
      rd_exp[1] = 32'h0;
      acc_n     = 0;
    end else begin
      case (m_phase)
        0: begin
          elig = {vld[1], vld[0]} & ~m_done;
          if (elig != 2'b00) begin
            if (elig == 2'b11) win = (m_last == 1) ? 0 : 1;
            else               win = elig[1] ? 1 : 0;
            m_owner = win;
            m_last  = win;
            bus     = cur[win];
            m_phase = 1;
            w_cur   = (waits.size() > 0) ? waits.pop_front() : int'($urandom_range(0, 3));
          end
        end
        1: begin
          m_phase = 2;
          acc_n   = 1;
        end
        default: begin
          if (tim_pready) begin
            done_n[m_owner] = 1'b1;
            if (!bus.wr) rd_exp[m_owner] = tim_prdata;
            m_phase = 0;
          end else if (TO_EN && acc_n == TIMEOUT) begin
            done_n[m_owner] = 1'b1;
            err_n[m_owner]  = 1'b1;
            rd_exp[m_owner] = 32'h0;
            m_phase = 0;
          end else begin
            acc_n++;
          end
        end
      endcase
    end
    m_done = done_n;
    m_err  = err_n;
    if (m_phase == 1) order_log.push_back(tim_paddr[31]);

    check_eq("psel", tim_psel, m_phase != 0);
    check_eq("penable", tim_penable, m_phase == 2);
    if (m_phase != 0) check_eq("bus", {tim_pwrite, tim_paddr, tim_pwdata}, {bus.wr, bus.addr, bus.wdata});
    else              check_eq("bus_idle", {tim_pwrite, tim_paddr, tim_pwdata}, 65'h0);
    check_eq("done", {req1_done, req0_done}, m_done);
    check_eq("err", {req1_err, req0_err}, m_err);
    check_eq("rdata0", req0_rdata, rd_exp[0]);
    check_eq("rdata1", req1_rdata, rd_exp[1]);

    // requester agents: drop on done, present next item after its gap
    for (int p = 0; p < 2; p++) begin
      if (m_done[p]) vld[p] = 1'b0;
    end
    if (!vld[0] && rq0.size() > 0) begin
      if (gapc[0] >= rq0[0].gap) begin cur[0] = rq0.pop_front(); vld[0] = 1'b1; gapc[0] = 0; end
      else gapc[0]++;
    end
    if (!vld[1] && rq1.size() > 0) begin
      if (gapc[1] >= rq1[0].gap) begin cur[1] = rq1.pop_front(); vld[1] = 1'b1; gapc[1] = 0; end
      else gapc[1]++;
    end
    req0_valid = vld[0]; req0_write = cur[0].wr; req0_addr = cur[0].addr; req0_wdata = cur[0].wdata;
    req1_valid = vld[1]; req1_write = cur[1].wr; req1_addr = cur[1].addr; req1_wdata = cur[1].wdata;

    // APB slave: pready after w_cur wait cycles, noise outside ACCESS
    if (m_phase == 2 && !sys_rst) begin
      tim_pready = (acc_n == w_cur + 1);
      if (tim_pready) tim_prdata = (rdq.size() > 0) ? rdq.pop_front() : $urandom;
      else            tim_prdata = $urandom;
    end else begin
      tim_pready = 1'($urandom_range(0, 1));
      tim_prdata = $urandom;
    end
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((rq0.size() + rq1.size() + int'(vld[0]) + int'(vld[1])) != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, rq0.size() + rq1.size() + int'(vld[0]) + int'(vld[1]), 0);
    tick();
    tick();
  endtask

  function automatic item_t mk(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int gap);
    item_t it;
    it.wr = wr; it.addr = addr; it.wdata = wdata; it.gap = gap;
    return it;
  endfunction

  initial begin
    int n;
    sys_rst = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
    tim_pready = 1'b0; tim_prdata = 32'h0;
    for (int p = 0; p < 2; p++) begin
      vld[p] = 1'b0; gapc[p] = 0; rd_exp[p] = 32'h0;
      cur[p] = mk(1'b0, 32'h0, 32'h0, 0);
    end
    m_phase = 0; m_last = 1; m_done = 2'b00; m_err = 2'b00; acc_n = 0; w_cur = 0;
    bus = mk(1'b0, 32'h0, 32'h0, 0);

    // reset held for three cycles: every output at 0
    repeat (3) tick();
    sys_rst = 1'b0;

    // single write from req0, slave ready at once
    rq0.push_back(mk(1'b1, 32'h0000_0000, 32'h0000_0001, 0));
    waits.push_back(0);
    run_drain("t_write_drain", 50);

    // read from req1 with three wait states
    rq1.push_back(mk(1'b0, 32'h8000_0004, 32'h0, 0));
    waits.push_back(3);
    rdq.push_back(32'h1234_5678);
    run_drain("t_read_drain", 50);
    check_eq("t_read_rdata", req1_rdata, 32'h1234_5678);

    // contention: both valid together, four transfers each
    order_log.delete();
    for (int i = 0; i < 4; i++) begin
      rq0.push_back(mk(1'($urandom_range(0, 1)), {1'b0, 29'($urandom), 2'b00}, $urandom, 0));
      rq1.push_back(mk(1'($urandom_range(0, 1)), {1'b1, 29'($urandom), 2'b00}, $urandom, 0));
      waits.push_back(0);
      waits.push_back(0);
    end
    run_drain("t_rr_drain", 200);
    check_eq("t_rr_count", order_log.size(), 8);
    for (int i = 0; i < order_log.size(); i++) check_eq("t_rr_order", order_log[i], i % 2);

    // reset in the middle of ACCESS, then the held request completes
    rq0.push_back(mk(1'b0, 32'h0000_0010, 32'h0, 0));
    waits.push_back(5);
    n = 0;
    while (m_phase != 2 && n < 50) begin tick(); n++; end
    check_eq("t_rst_reach_access", m_phase, 2);
    tick();
    sys_rst = 1'b1;
    #1;
    check_eq("t_rst_psel", tim_psel, 1'b0);
    check_eq("t_rst_penable", tim_penable, 1'b0);
    check_eq("t_rst_done", {req1_done, req0_done}, 2'b00);
    tick();
    tick();
    sys_rst = 1'b0;
    run_drain("t_rst_drain", 50);

    if (TO_EN) begin
      // slave never answers: watchdog completes with err
      rq0.push_back(mk(1'b0, 32'h0000_0020, 32'h0, 0));
      waits.push_back(1000);
      run_drain("t_to_expire_drain", 100);
      // pready lands exactly in the last allowed cycle: normal completion
      rq0.push_back(mk(1'b0, 32'h0000_0024, 32'h0, 0));
      waits.push_back(TIMEOUT - 1);
      rdq.push_back(32'hCAFE_0016);
      run_drain("t_to_edge_drain", 100);
      check_eq("t_to_edge_rdata", req0_rdata, 32'hCAFE_0016);
    end else begin
      // long stall: no done and no err until pready
      rq0.push_back(mk(1'b0, 32'h0000_0020, 32'h0, 0));
      waits.push_back(40);
      rdq.push_back(32'h0BAD_F00D);
      run_drain("t_stall_drain", 100);
      check_eq("t_stall_rdata", req0_rdata, 32'h0BAD_F00D);
    end

    // randomized traffic on both ports
    for (int i = 0; i < 30; i++) begin
      rq0.push_back(mk(1'($urandom_range(0, 1)), {1'b0, 29'($urandom), 2'b00}, $urandom,
                       ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4))));
      rq1.push_back(mk(1'($urandom_range(0, 1)), {1'b1, 29'($urandom), 2'b00}, $urandom,
                       ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4))));
    end
    run_drain("t_rand_drain", 3000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/tim_apb_arbiter.md
# tim_apb_arbiter

Two-port APB master arbiter for the timer register bank. It lets two independent requesters share the single timer APB slave port: a CPU-side bridge and an autonomous configuration sequencer. It accepts simple word-wide read/write requests, arbitrates round-robin, and drives compliant APB SETUP/ACCESS phases onto the `tim_*` bus. Each requester gets its own completion pulse, read data and error flag.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS-phase cycles to wait for `tim_pready`; used only with the timeout macro.
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  request pending; held until the matching `done`.
- `req0_write` / `req1_write`  in  1  1 = write, 0 = read; stable while valid.
- `req0_addr` / `req1_addr`  in  32  register byte address.
- `req0_wdata` / `req1_wdata`  in  32  write data.
- `req0_done` / `req1_done`  out  1  one-cycle completion pulse.
- `req0_rdata` / `req1_rdata`  out  32  read data; valid with `done`, held until the next completion on that port.
- `req0_err` / `req1_err`  out  1  timeout error, valid with `done`.
- `tim_psel`, `tim_penable`, `tim_pwrite`  out  1  APB control.
- `tim_paddr`, `tim_pwdata`  out  32  APB address and write data.
- `tim_prdata`  in  32  APB read data.
- `tim_pready`  in  1  APB ready.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- **IDLE**
  - Sample valid requesters.
  - A requester whose `done` is high this cycle is excluded from sampling.
  - On grant, latch write, addr and wdata from the winner and go to SETUP.
- **SETUP**: `psel`=1, `penable`=0. Go unconditionally to ACCESS.
- **ACCESS**: `psel`=1, `penable`=1. Stay until `tim_pready`=1.
  - On `tim_pready`=1, capture `tim_prdata` (reads only) into the winner's rdata.
  - Then go to IDLE and pulse the winner's `done` in the next cycle.
- **Arbitration**
  - With a single valid requester, that requester wins.
  - With both valid, the requester not granted last wins.
  - `last_grant` resets to 1, so req0 wins the first tie.
- **Bus when idle**: `tim_paddr`, `tim_pwdata` and `tim_pwrite` are driven to 0 whenever the FSM is in IDLE.
- **Write reads**: on a write, rdata is not updated.
- **Reset** (any time, including mid-transfer)
  - FSM returns to IDLE; the in-flight transfer is dropped with no `done`.
  - All outputs are 0; `last_grant`=1.

## Timing
- Valid sampled in IDLE at edge k gives: SETUP in cycle k+1, ACCESS in k+2, and with `pready` already high, `done` in cycle k+3.
- Minimum transfer is 3 cycles. Each wait-state cycle in ACCESS adds 1.
- Back-to-back transfers:
  - The next grant can be sampled in the same IDLE cycle in which `done` pulses.
  - SETUP follows immediately, so the bus is idle for exactly one cycle between transfers.
- `tim_paddr`, `tim_pwrite` and `tim_pwdata` are stable from SETUP through the last ACCESS cycle.
- `done`, `rdata` and `err` are registered; there is no combinational path from `tim_pready` to any requester output.

## Configuration
- Macro: `TIM_ARB_TIMEOUT_EN`.
- **Defined**
  - A 5-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - When the count reaches `TIMEOUT_CYCLES`, the FSM drops `psel`/`penable`, returns to IDLE, and pulses `done` with `err`=1 and rdata=0.
  - `pready` arriving in the same cycle as expiry takes priority: normal completion, `err`=0.
- **Undefined**
  - ACCESS waits indefinitely.
  - `req*_err` are tied to 0 and the counter is not instantiated.

## Structure
- Package `tim_arb_pkg`:
  - State encoding: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - `TIM_ADDR_W`=32, `TIM_DATA_W`=32.
  - Default `TIMEOUT_CYCLES`.
- Sub-module `tim_arb_rr`: combinational two-way round-robin picker.
  - Inputs: `valid[1:0]`, `last_grant`, `exclude[1:0]`.
  - Outputs: `grant[1:0]` (one-hot or zero).
- The top level holds the FSM, the request latch, the per-port output registers and the optional timeout counter.

## Test plan
- Reset: hold `sys_rst`=1 for 3 cycles → all outputs 0. Release and issue a req0 write of 0x0000_0001 to 0x00 with `pready` tied 1 → `psel` high 2 cycles, `req0_done` in cycle k+3.
- Read with wait states: req1 reads 0x04, slave holds `pready`=0 for 3 cycles, then returns 0x1234_5678 → ACCESS lasts 4 cycles, `req1_rdata`=0x1234_5678, `req1_err`=0.
- Contention: req0 and req1 both valid at the same edge after reset, repeated for 4 transfers each → bus order req0, req1, req0, req1…; one idle cycle between transfers.
- Reset mid-transfer: assert `sys_rst` during ACCESS → `psel` and `penable` drop immediately; no `done` pulses; the next transfer after release proceeds normally.
- With `TIM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: slave never asserts `pready` → `req0_done`=1 with `req0_err`=1 and rdata=0 after 16 ACCESS cycles. Repeat with `pready` asserted exactly at cycle 16 → `err`=0.
- Without the macro, stall `pready` for 40 cycles → no `done` until `pready` rises; `err` stays 0.
